// File: rtl/mips_pkg.sv
// Shared datapath constants and the register-file clear/run state encoding.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } regfile_state_t;
endpackage

// File: rtl/register_file_if.sv
// Writeback-to-register-file and decode read-port signal bundle.
interface register_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              RegWrite;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic [ADDR_W-1:0] readReg1;
  logic [ADDR_W-1:0] readReg2;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic              ready;

  modport master (
    output RegWrite, writeReg, writeData, readReg1, readReg2,
    input  readData1, readData2, ready
  );

  modport slave (
    input  RegWrite, writeReg, writeData, readReg1, readReg2,
    output readData1, readData2, ready
  );
endinterface

// File: rtl/regfile_clear_seq.sv
// Post-reset sequencer: zeroes one register-file entry per cycle, then raises ready.
// state | meaning
// CLEAR | walking clrPtr over the array, writing zeros; array out of service
// RUN   | clear finished, array in service
module regfile_clear_seq #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  output logic              clrEn,
  output logic [ADDR_W-1:0] clrAddr,
  output logic              ready
);
  import mips_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;
  // One extra pointer bit so the terminal compare never aliases after the last entry.
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W + 1)'(1);

  regfile_state_t    r_state, w_next_state;
  logic [ADDR_W:0]   r_clr_ptr, w_next_ptr;
  logic              r_ready, w_next_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_clr_ptr <= w_next_ptr;
      r_ready   <= w_next_ready;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_ptr   = r_clr_ptr;
    w_next_ready = r_ready;
    clrEn        = 1'b0;
    case (r_state)
      CLEAR: begin
        clrEn      = 1'b1;
        w_next_ptr = r_clr_ptr + ONE;
        if (r_clr_ptr == LAST) begin
          w_next_state = RUN;
          w_next_ready = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign clrAddr = r_clr_ptr[ADDR_W-1:0];
  assign ready   = r_ready;
endmodule

// File: rtl/register_file.sv
// MIPS architectural register file: one write port shared with the clear sequencer,
// two combinational read ports with optional same-cycle write-through.
module register_file #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::REG_ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  register_file_if.slave  rf
);
  import mips_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_clr_en;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_ready;
  logic              w_wr_en;
  logic              w_byp1;
  logic              w_byp2;

  regfile_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
    .clk     (clk),
    .reset   (reset),
    .clrEn   (w_clr_en),
    .clrAddr (w_clr_addr),
    .ready   (w_ready)
  );

  assign w_wr_en = w_ready && rf.RegWrite && (rf.writeReg != '0);

  // Clear owns the write port until ready; upstream writes in that window are dropped.
  always_ff @(posedge clk) begin
    if (w_clr_en) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_en) begin
      r_mem[rf.writeReg] <= rf.writeData;
    end
  end

  assign w_byp1 = BYPASS && w_wr_en && (rf.writeReg == rf.readReg1);
  assign w_byp2 = BYPASS && w_wr_en && (rf.writeReg == rf.readReg2);

  always_comb begin
    rf.readData1 = '0;
    if (w_ready && (rf.readReg1 != '0)) begin
      rf.readData1 = w_byp1 ? rf.writeData : r_mem[rf.readReg1];
    end
  end

  always_comb begin
    rf.readData2 = '0;
    if (w_ready && (rf.readReg2 != '0)) begin
      rf.readData2 = w_byp2 ? rf.writeData : r_mem[rf.readReg2];
    end
  end

  assign rf.ready = w_ready;
endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: bypassing and non-bypassing instances driven in lockstep
// and compared against an array-based reference model.
module tb_register_file;
  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;

  always #5 clk = ~clk;

  register_file_if if_b ();
  register_file_if if_n ();

  assign if_b.RegWrite  = reg_write;
  assign if_b.writeReg  = write_reg;
  assign if_b.writeData = write_data;
  assign if_b.readReg1  = read_reg1;
  assign if_b.readReg2  = read_reg2;
  assign if_n.RegWrite  = reg_write;
  assign if_n.writeReg  = write_reg;
  assign if_n.writeData = write_data;
  assign if_n.readReg1  = read_reg1;
  assign if_n.readReg2  = read_reg2;

  register_file #(.BYPASS(1'b1)) dut_b (.clk(clk), .reset(reset), .rf(if_b.slave));
  register_file #(.BYPASS(1'b0)) dut_n (.clk(clk), .reset(reset), .rf(if_n.slave));

  logic [31:0] m_regs [32];
  bit          m_ready;
  int          m_cnt;
  int          n_pass;
  int          n_total;

  function automatic logic [31:0] exp_rd(input logic [4:0] rr, input bit byp);
    if (!m_ready || rr == 5'd0) return 32'h0;
    if (byp && reg_write && write_reg != 5'd0 && write_reg == rr) return write_data;
    return m_regs[rr];
  endfunction

  // Advance the model with the inputs present before the edge, then cross the edge.
  task automatic tick();
    if (reset) begin
      m_ready = 1'b0;
      m_cnt   = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == 32) m_ready = 1'b1;
    end else if (reg_write && write_reg != 5'd0) begin
      m_regs[write_reg] = write_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int cnt;
    reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = 5'd1; read_reg2 = 5'd2;
    tick(); tick();
    n_total++;
    if (if_b.ready !== 1'b0 || if_b.readData1 !== 32'h0) $display("FAIL reset_outputs: ready=%b rd1=%h, expected ready=0 rd1=0", if_b.ready, if_b.readData1);
    else n_pass++;
    reset = 1'b0;
    cnt = 0;
    while (if_b.ready !== 1'b1 && cnt < 40) begin tick(); cnt++; end
    n_total++;
    if (cnt !== 32) $display("FAIL powerup_clear_len: got %0d cycles, expected 32", cnt);
    else n_pass++;
  endtask

  task automatic test_clear_after_fill();
    int cnt;
    reg_write = 1'b1;
    for (int i = 1; i < 32; i++) begin write_reg = 5'(i); write_data = 32'hFFFF_FFFF; tick(); end
    reg_write = 1'b0; read_reg1 = 5'd7; read_reg2 = 5'd31; #1;
    n_total++;
    if (if_b.readData1 !== 32'hFFFF_FFFF || if_n.readData2 !== 32'hFFFF_FFFF) $display("FAIL fill_readback: got %h/%h, expected ffffffff", if_b.readData1, if_n.readData2);
    else n_pass++;
    reset = 1'b1; tick(); reset = 1'b0;
    cnt = 0;
    while (if_b.ready !== 1'b1 && cnt < 40) begin
      read_reg1 = 5'($urandom_range(1, 31)); #1;
      n_total++;
      if (if_b.ready !== m_ready || if_b.readData1 !== 32'h0) $display("FAIL during_clear: ready=%b rd1=%h, expected ready=%b rd1=0", if_b.ready, if_b.readData1, m_ready);
      else n_pass++;
      tick(); cnt++;
    end
    n_total++;
    if (cnt !== 32) $display("FAIL clear_len_after_fill: got %0d cycles, expected 32", cnt);
    else n_pass++;
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i); read_reg2 = 5'(31 - i); #1;
      n_total++;
      if (if_b.readData1 !== 32'h0 || if_b.readData2 !== 32'h0 || if_n.readData1 !== 32'h0) $display("FAIL wiped_reg r%0d: got %h/%h/%h, expected 0", i, if_b.readData1, if_b.readData2, if_n.readData1);
      else n_pass++;
    end
  endtask

  task automatic test_write_read();
    reg_write = 1'b1; write_reg = 5'd5; write_data = 32'hDEAD_BEEF; tick();
    reg_write = 1'b0; read_reg1 = 5'd5; read_reg2 = 5'd6; #1;
    n_total++;
    if (if_n.readData1 !== 32'hDEAD_BEEF || if_b.readData1 !== 32'hDEAD_BEEF) $display("FAIL write_read_r5: got %h/%h, expected deadbeef", if_b.readData1, if_n.readData1);
    else n_pass++;
    n_total++;
    if (if_b.readData2 !== 32'h0) $display("FAIL read_r6: got %h, expected 0", if_b.readData2);
    else n_pass++;
  endtask

  task automatic test_zero();
    reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h1234_5678; read_reg1 = 5'd0; read_reg2 = 5'd0; #1;
    n_total++;
    if (if_b.readData1 !== 32'h0 || if_b.readData2 !== 32'h0) $display("FAIL zero_same_cycle: got %h/%h, expected 0", if_b.readData1, if_b.readData2);
    else n_pass++;
    tick(); reg_write = 1'b0; #1;
    n_total++;
    if (if_b.readData1 !== 32'h0 || if_n.readData1 !== 32'h0) $display("FAIL zero_next_cycle: got %h/%h, expected 0", if_b.readData1, if_n.readData1);
    else n_pass++;
  endtask

  task automatic test_bypass();
    reg_write = 1'b1; write_reg = 5'd9; write_data = 32'h1; tick();
    write_data = 32'h2; read_reg1 = 5'd9; read_reg2 = 5'd9; #1;
    n_total++;
    if (if_b.readData1 !== 32'h2 || if_b.readData2 !== 32'h2) $display("FAIL bypass_on: got %h/%h, expected 2/2", if_b.readData1, if_b.readData2);
    else n_pass++;
    n_total++;
    if (if_n.readData1 !== 32'h1 || if_n.readData2 !== 32'h1) $display("FAIL bypass_off_old: got %h/%h, expected 1/1", if_n.readData1, if_n.readData2);
    else n_pass++;
    tick(); reg_write = 1'b0; #1;
    n_total++;
    if (if_n.readData1 !== 32'h2 || if_n.readData2 !== 32'h2) $display("FAIL bypass_off_new: got %h/%h, expected 2/2", if_n.readData1, if_n.readData2);
    else n_pass++;
  endtask

  task automatic test_mid_clear_reset();
    int cnt;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    cnt = 0;
    while (if_b.ready !== 1'b1 && cnt < 40) begin tick(); cnt++; end
    n_total++;
    if (cnt !== 32) $display("FAIL mid_clear_restart: got %0d cycles, expected 32", cnt);
    else n_pass++;
  endtask

  task automatic test_write_during_clear();
    int cnt;
    reset = 1'b1; tick(); reset = 1'b0;
    reg_write = 1'b1; write_reg = 5'd3; write_data = 32'hAA;
    cnt = 0;
    while (if_b.ready !== 1'b1 && cnt < 40) begin tick(); cnt++; end
    reg_write = 1'b0; read_reg1 = 5'd3; read_reg2 = 5'd3; #1;
    n_total++;
    if (if_b.ready !== 1'b1 || if_b.readData1 !== 32'h0 || if_n.readData2 !== 32'h0) $display("FAIL write_during_clear: ready=%b r3=%h/%h, expected ready=1 r3=0", if_b.ready, if_b.readData1, if_n.readData2);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 149) == 0);
      reg_write  = ($urandom_range(0, 3) != 0);
      write_reg  = 5'($urandom_range(0, 31));
      write_data = $urandom;
      read_reg1  = ($urandom_range(0, 1) == 1) ? write_reg : 5'($urandom_range(0, 31));
      read_reg2  = ($urandom_range(0, 2) == 0) ? write_reg : 5'($urandom_range(0, 31));
      #1;
      n_total++;
      if (if_b.ready !== m_ready || if_b.readData1 !== exp_rd(read_reg1, 1'b1) || if_b.readData2 !== exp_rd(read_reg2, 1'b1))
        $display("FAIL rand_bypass[%0d]: ready=%b rd1=%h rd2=%h, expected ready=%b rd1=%h rd2=%h", i, if_b.ready, if_b.readData1, if_b.readData2, m_ready, exp_rd(read_reg1, 1'b1), exp_rd(read_reg2, 1'b1));
      else n_pass++;
      n_total++;
      if (if_n.ready !== m_ready || if_n.readData1 !== exp_rd(read_reg1, 1'b0) || if_n.readData2 !== exp_rd(read_reg2, 1'b0))
        $display("FAIL rand_nobypass[%0d]: ready=%b rd1=%h rd2=%h, expected ready=%b rd1=%h rd2=%h", i, if_n.ready, if_n.readData1, if_n.readData2, m_ready, exp_rd(read_reg1, 1'b0), exp_rd(read_reg2, 1'b0));
      else n_pass++;
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_total = 0; m_ready = 1'b0; m_cnt = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    test_reset();
    test_clear_after_fill();
    test_write_read();
    test_zero();
    test_bypass();
    test_mid_clear_reset();
    test_write_during_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
